// File: rtl/instruction_loader.sv
// Byte-stream instruction image loader feeding the processor's instruction-initialisation port.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_init_wadrs,
    output logic [DATA_WIDTH-1:0]    ram_write_instruction,
    output logic                     initialize_instructions,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH:0]   words_loaded
);

    // state   | meaning
    // IDLE    | waiting for start after reset
    // HDR_LO  | receiving word-count low byte
    // HDR_HI  | receiving word-count high byte, range check
    // COLLECT | assembling a little-endian word
    // COMMIT  | presenting address/data to the RAM write port
    // CKSUM   | receiving checksum byte (checksum build only)
    // FLUSH   | one extra write edge with final address/data
    // DONE    | image loaded, write port released
    // ERROR   | bad header or checksum, left only by reset

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam int unsigned MAX_WORDS = (1 << ADDRESS_WIDTH) - BASE_ADDR;
    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_COLLECT,
        S_COMMIT,
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 state;
    logic [7:0]             hdr_lo;
    logic [15:0]            n_words;
    logic [BIDX_W-1:0]      byte_idx;
    logic [ADDRESS_WIDTH:0] word_idx;
    logic [DATA_WIDTH-1:0]  word_buf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    logic        xfer;
    logic [15:0] hdr_n;
    logic        more_words;

    assign xfer       = byte_valid && byte_ready;
    assign hdr_n      = {byte_data, hdr_lo};
    assign more_words = (32'(word_idx) + 32'd1) < 32'(n_words);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= S_IDLE;
            hdr_lo                  <= '0;
            n_words                 <= '0;
            byte_idx                <= '0;
            word_idx                <= '0;
            word_buf                <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum                    <= '0;
`endif
            byte_ready              <= 1'b0;
            ram_init_wadrs          <= '0;
            ram_write_instruction   <= '0;
            initialize_instructions <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            error                   <= 1'b0;
            words_loaded            <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Entering DONE from FLUSH releases the processor on this edge
                    initialize_instructions <= 1'b0;
                    if (start) begin
                        state        <= S_HDR_LO;
                        byte_ready   <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        word_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end else if (state == S_DONE) begin
                        done <= 1'b1;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        hdr_lo <= byte_data;
                        state  <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        n_words <= hdr_n;
                        if (hdr_n == 16'd0 || 32'(hdr_n) > MAX_WORDS) begin
                            state      <= S_ERROR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        word_buf[8*byte_idx +: 8] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx   <= '0;
                            byte_ready <= 1'b0;
                            state      <= S_COMMIT;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    ram_init_wadrs          <= BASE + word_idx[ADDRESS_WIDTH-1:0];
                    ram_write_instruction   <= word_buf;
                    initialize_instructions <= 1'b1;
                    words_loaded            <= words_loaded + 1'b1;
                    word_idx                <= word_idx + 1'b1;
                    if (more_words) begin
                        state      <= S_COLLECT;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state      <= S_CKSUM;
                        byte_ready <= 1'b1;
`else
                        state      <= S_FLUSH;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state <= S_FLUSH;
                        end else begin
                            // Write port stays claimed so a corrupt image never runs
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                S_FLUSH: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table-driven loads with a commit scoreboard,
// plus hand sequences for mid-load reset and the optional checksum byte.
module tb_instruction_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start1, start2, byte_valid, sel;
    logic [7:0]  byte_data;

    logic        rdy1, init1, busy1, done1, err1;
    logic [11:0] addr1;
    logic [31:0] data1;
    logic [12:0] wl1;
    logic        rdy2, init2, busy2, done2, err2;
    logic [11:0] addr2;
    logic [31:0] data2;
    logic [12:0] wl2;

    instruction_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start1), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(rdy1), .ram_init_wadrs(addr1), .ram_write_instruction(data1),
        .initialize_instructions(init1), .busy(busy1), .done(done1), .error(err1), .words_loaded(wl1));

    instruction_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR('hFFE)) dut_hi (
        .clk(clk), .reset(reset), .start(start2), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(rdy2), .ram_init_wadrs(addr2), .ram_write_instruction(data2),
        .initialize_instructions(init2), .busy(busy2), .done(done2), .error(err2), .words_loaded(wl2));

    logic        m_ready, m_init, m_busy, m_done, m_err;
    logic [11:0] m_addr;
    logic [31:0] m_data;
    logic [12:0] m_wl;
    assign m_ready = sel ? rdy2  : rdy1;
    assign m_init  = sel ? init2 : init1;
    assign m_busy  = sel ? busy2 : busy1;
    assign m_done  = sel ? done2 : done1;
    assign m_err   = sel ? err2  : err1;
    assign m_addr  = sel ? addr2 : addr1;
    assign m_data  = sel ? data2 : data1;
    assign m_wl    = sel ? wl2   : wl1;

`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];

    int   prev_wl = 0;
    logic prev_init = 1'b0;
    int   init_rises = 0;
    int   init_cycles = 0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (int'(m_wl) != prev_wl) begin
            if (int'(m_wl) == prev_wl + 1) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_commit: got addr %0h data %0h, expected no commit", m_addr, m_data);
                end else begin
                    e = sbq.pop_front();
                    check("commit_addr", m_addr, e.a);
                    check("commit_data", m_data, e.d);
                end
            end
            prev_wl = int'(m_wl);
        end
        if (m_init && !prev_init) init_rises++;
        if (m_init) init_cycles++;
        prev_init = m_init;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        init_rises  = 0;
        init_cycles = 0;
    endtask

    task automatic pulse_start();
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int cnt = 0;
        if (toggle) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_data  = b;
        byte_valid = 1'b1;
        while (!m_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte_ready stayed 0, expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle, input logic [11:0] a);
        sbq.push_back({a, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], toggle);
        check("ready_low_in_commit", m_ready, 1'b0);
    endtask

    task automatic wait_end();
        int cnt = 0;
        while (!m_done && !m_err && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) begin
            tests++;
            fails++;
            $display("FAIL end_timeout: done=%0d error=%0d, expected one of them set", m_done, m_err);
        end
    endtask

    task automatic check_reset_state();
        check("rst_addr", m_addr, 12'h000);
        check("rst_data", m_data, 32'h0);
        check("rst_flags", {m_ready, m_init, m_busy, m_done, m_err}, 5'b0);
        check("rst_words", m_wl, 13'd0);
    endtask

    typedef struct {
        logic [15:0]       n;
        bit                sel;
        bit                toggle;
        bit                err;
        logic [2:0][31:0]  w;
    } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        logic [11:0] base;
        logic [7:0]  ck;
        logic        seen;
        base = v.sel ? 12'hFFE : 12'h000;
        ck   = 8'h00;
        pulse_start();
        check("busy_after_start", m_busy, 1'b1);
        send_byte(v.n[7:0], v.toggle);
        send_byte(v.n[15:8], v.toggle);
        if (v.err) begin
            check("hdr_error", m_err, 1'b1);
            check("hdr_err_busy", m_busy, 1'b0);
            byte_valid = 1'b1;
            seen = 1'b0;
            repeat (5) begin
                @(negedge clk);
                seen = seen | m_ready | m_init;
            end
            check("err_ready_init_low", seen, 1'b0);
            check("err_sticky", m_err, 1'b1);
            check("err_no_init_rise", init_rises, 0);
            byte_valid = 1'b0;
        end else begin
            for (int i = 0; i < int'(v.n); i++) begin
                send_word(v.w[i], v.toggle, base + 12'(i));
                ck = ck ^ v.w[i][7:0] ^ v.w[i][15:8] ^ v.w[i][23:16] ^ v.w[i][31:24];
            end
            if (CK == 1) send_byte(ck, v.toggle);
            byte_valid = 1'b0;
            wait_end();
            check("load_done", {m_done, m_err, m_init, m_busy}, 4'b1000);
            check("load_words", m_wl, 13'(v.n));
            check("init_single_pulse", init_rises, 1);
            check("scoreboard_empty", sbq.size(), 0);
            if (!v.toggle) check("init_cycles", init_cycles, 5 * (int'(v.n) - 1) + 2 + CK);
        end
    endtask

    initial begin
        vecs[0] = '{n: 16'd1,    sel: 1'b0, toggle: 1'b0, err: 1'b0, w: {32'h0, 32'h0, 32'h12345678}};
        vecs[1] = '{n: 16'd3,    sel: 1'b0, toggle: 1'b1, err: 1'b0, w: {32'h0F1E2D3C, 32'hDEADBEEF, 32'hA5A50001}};
        vecs[2] = '{n: 16'd0,    sel: 1'b0, toggle: 1'b0, err: 1'b1, w: '0};
        vecs[3] = '{n: 16'h1001, sel: 1'b0, toggle: 1'b0, err: 1'b1, w: '0};
        vecs[4] = '{n: 16'd2,    sel: 1'b0, toggle: 1'b0, err: 1'b0, w: {32'h0, 32'h00000080, 32'hFFFFFFFF}};
        vecs[5] = '{n: 16'd2,    sel: 1'b1, toggle: 1'b0, err: 1'b0, w: {32'h0, 32'hCAFEF00D, 32'h01020304}};
        vecs[6] = '{n: 16'd3,    sel: 1'b1, toggle: 1'b1, err: 1'b1, w: '0};

        sel = 1'b0;
        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].sel;
            do_reset();
            check_reset_state();
            run_vec(vecs[v]);
        end

        // Reset after the second of three words, then a clean reload
        sel = 1'b0;
        do_reset();
        pulse_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h11112222, 1'b0, 12'h000);
        send_word(32'h33334444, 1'b0, 12'h001);
        byte_valid = 1'b0;
        @(negedge clk);
        check("mid_words_before_reset", m_wl, 13'd2);
        check("mid_init_before_reset", m_init, 1'b1);
        check("mid_sb_drained", sbq.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        sbq.delete();
        init_rises = 0;
        init_cycles = 0;
        run_vec('{n: 16'd3, sel: 1'b0, toggle: 1'b0, err: 1'b0, w: {32'h9ABCDEF0, 32'h55AA55AA, 32'h76543210}});

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            do_reset();
            pulse_start();
            send_byte(8'h01, 1'b0);
            send_byte(8'h00, 1'b0);
            send_word(32'h12345678, 1'b0, 12'h000);
            send_byte((k == 0) ? 8'h08 : 8'h09, 1'b0);
            byte_valid = 1'b0;
            if (k == 0) begin
                wait_end();
                check("cksum_ok_done", {m_done, m_err, m_init}, 3'b100);
            end else begin
                check("cksum_bad_error", m_err, 1'b1);
                check("cksum_bad_init_held", m_init, 1'b1);
                check("cksum_bad_ready", m_ready, 1'b0);
                repeat (3) @(negedge clk);
                check("cksum_bad_still", {m_err, m_init, m_done}, 3'b110);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream feeder for the processor FSM's instruction-initialisation port.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word-count header, then little-endian instruction words.
- Drives ram_init_wadrs, ram_write_instruction and initialize_instructions so the processor's WRITE state loads instruction RAM.
- Releases initialize_instructions once the image is complete, which lets the processor proceed to FETCH.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- ADDRESS_WIDTH, 12, RAM address width.
- BASE_ADDR, 0, RAM address of the first loaded word.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a load; sampled only in IDLE or DONE.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- ram_init_wadrs  output  ADDRESS_WIDTH  RAM write address for the current word.
- ram_write_instruction  output  DATA_WIDTH  assembled instruction word.
- initialize_instructions  output  1  holds the processor in WRITE and enables RAM writes.
- busy  output  1  load in progress (HDR_LO through FLUSH).
- done  output  1  level; image loaded successfully.
- error  output  1  level; sticky until reset.
- words_loaded  output  ADDRESS_WIDTH+1  count of committed words.

Behaviour:
- Reset state: IDLE. All outputs 0, including ram_init_wadrs, ram_write_instruction, byte_ready and initialize_instructions.
- Reset mid-load: everything clears on that edge and initialize_instructions drops on that edge.
- All outputs are registered.
- A transfer occurs when byte_valid && byte_ready on a rising edge.
- byte_ready = 1 only in HDR_LO, HDR_HI, COLLECT and CKSUM.
- States and transitions:
  - IDLE: start -> HDR_LO. Clears words_loaded, byte index, word index and checksum.
  - HDR_LO: transfer -> latch N[7:0], go to HDR_HI.
  - HDR_HI: transfer -> latch N[15:8].
    - Error if N == 0 or N > 2^ADDRESS_WIDTH - BASE_ADDR -> ERROR; initialize_instructions is never raised.
    - Otherwise -> COLLECT.
  - COLLECT: each transfer shifts the byte into lane byte_idx; first byte is bits [7:0] (little-endian). On the BYTES-th byte -> COMMIT.
  - COMMIT (1 cycle): update three outputs on the same edge:
    - ram_init_wadrs <= BASE_ADDR + word_idx.
    - ram_write_instruction <= assembled word.
    - initialize_instructions <= 1.
    - Also words_loaded++ and word_idx++. Next state: word_idx+1 < N -> COLLECT, else FLUSH (or CKSUM, see Optional Feature).
  - FLUSH (1 cycle): outputs held, guaranteeing at least one RAM write edge with the final address/data. Then -> DONE.
  - DONE: initialize_instructions <= 0 on entry; done = 1; ram_init_wadrs and ram_write_instruction hold their last values. start -> HDR_LO with done cleared.
  - ERROR: error = 1; byte_ready = 0. initialize_instructions holds its current value, so an aborted partial image keeps the processor parked in WRITE rather than executing. Only reset exits ERROR.
- Address and data change only in COMMIT, and always together. Between commits the RAM rewrites the previous word with identical data, which is harmless.
- Address arithmetic is ADDRESS_WIDTH wide; wrap cannot occur because of the header check.
- start outside IDLE/DONE is ignored. byte_valid outside ready states is ignored; bytes are not consumed.
- Latency: last payload byte accepted -> initialize_instructions low is 3 edges (COMMIT, FLUSH, DONE).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes, excluding the header, is kept.
  - After the final COMMIT, the next state is CKSUM instead of FLUSH; CKSUM accepts one byte.
  - Byte equals running XOR -> FLUSH -> DONE.
  - Mismatch -> ERROR, with initialize_instructions held at 1.
- Undefined: no CKSUM state and no checksum register; the final COMMIT goes directly to FLUSH.

Test Plan:
- Reset, then start, stream 01 00 | 78 56 34 12 with byte_valid held high.
  - ram_init_wadrs=0 and ram_write_instruction=0x12345678 appear the edge after the 4th payload byte.
  - initialize_instructions is high 2 cycles, then done=1, words_loaded=1.
- N=3 with byte_valid toggling every other cycle.
  - Addresses 0,1,2 each committed with the correct words.
  - byte_ready drops during COMMIT.
  - initialize_instructions stays high continuously until DONE.
- Header 00 00, and separately header 01 10 (N=4097).
  - error=1 and initialize_instructions never asserted.
  - byte_ready=0 until reset.
- reset asserted after the 2nd of 3 words.
  - Next edge: all outputs 0, state IDLE.
  - A subsequent start plus a full stream loads correctly.
- BASE_ADDR=0xFFE, N=2 loads 0xFFE and 0xFFF; N=3 -> ERROR.
- With LOADER_CHECKSUM_EN, N=1, word 0x12345678:
  - Checksum byte 0x08 -> done=1.
  - Checksum byte 0x09 -> error=1, initialize_instructions remains 1.
